mem_port_arbiter: RTL and testbench

- Shares one multi-cycle backing memory port between the instruction-fetch requester and the data-memory requester.
- Sits between fetch/memory stages and the unified memory model. Returns the 2-bit status codes the pipeline uses for stall/resume (2'b10 = done).
- Caches the last completed result per requester, so a held request reads as done without re-accessing memory.

---
 rtl/mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle backing memory port between
// instruction fetch and data access, caching the last result per requester.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        i_status,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic [1:0]        d_status,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_I,
        ST_BUSY_D
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_iv;
    logic [ADDR_W-1:0] r_iaddr;
    logic [DATA_W-1:0] r_idata;
    logic              r_ierr;

    logic              r_dv;
    logic [ADDR_W-1:0] r_daddr;
    logic              r_dwe;
    logic [DATA_W-1:0] r_dwdata;
    logic [DATA_W-1:0] r_ddata;
    logic              r_derr;

    logic [SW-1:0]     r_starve;
    logic [TW-1:0]     r_tcnt;

    logic              r_mreq;
    logic              r_mwe;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_mwdata;
    logic              r_err;

    logic w_i_hit;
    logic w_d_hit;
    logic w_i_cand;
    logic w_d_cand;
    logic w_busy;
    logic w_tmo;
    logic w_grant_i;
    logic w_grant_d;
    logic w_done;
    logic w_abort;

    assign w_i_hit = i_req && r_iv && (i_addr == r_iaddr);
    assign w_d_hit = d_req && r_dv && (d_addr == r_daddr)
                  && (d_we == r_dwe)
                  && (!d_we || (d_wdata == r_dwdata));

    // A requester with a latched error waits for its req to drop
    // instead of being retried behind an 11 status.
    assign w_i_cand = i_req && !w_i_hit && !r_ierr;
    assign w_d_cand = d_req && !w_d_hit && !r_derr;

    assign w_busy = (r_state != ST_IDLE);
    assign w_tmo  = (r_tcnt == TMO_LAST);

    function automatic logic [1:0] f_status(
        input logic req,
        input logic hit,
        input logic errl
    );
        logic [1:0] s;
        if (!req)      s = 2'b00;
        else if (hit)  s = 2'b10;
        else if (errl) s = 2'b11;
        else           s = 2'b01;
        return s;
    endfunction

    assign i_status = rst ? f_status(i_req, w_i_hit, r_ierr) : 2'b00;
    assign d_status = rst ? f_status(d_req, w_d_hit, r_derr) : 2'b00;

    assign i_rdata = r_idata;
    assign d_rdata = r_ddata;
    assign m_req   = r_mreq;
    assign m_we    = r_mwe;
    assign m_addr  = r_maddr;
    assign m_wdata = r_mwdata;
    assign err     = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_i_cand && w_d_cand) begin
                    if (r_starve == STARVE_LIM) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (w_i_cand) begin
                    w_grant_i = 1'b1;
                end else if (w_d_cand) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i) begin
                    w_state_nxt = ST_BUSY_I;
                end else if (w_grant_d) begin
                    w_state_nxt = ST_BUSY_D;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (m_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Backing port: the request is snapshotted at grant and held to the end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mreq   <= 1'b0;
            r_mwe    <= 1'b0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_tcnt   <= '0;
            r_starve <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_grant_i) begin
                r_mreq   <= 1'b1;
                r_mwe    <= 1'b0;
                r_maddr  <= i_addr;
                r_mwdata <= '0;
            end else if (w_grant_d) begin
                r_mreq   <= 1'b1;
                r_mwe    <= d_we;
                r_maddr  <= d_addr;
                r_mwdata <= d_wdata;
            end else if (w_done || w_abort) begin
                r_mreq   <= 1'b0;
            end

            if (w_grant_i || w_grant_d) begin
                r_tcnt <= '0;
            end else if (w_busy) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_grant_i) begin
                r_starve <= '0;
            end else if (w_grant_d && w_i_cand
                         && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + 1'b1;
            end

            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iv    <= 1'b0;
            r_iaddr <= '0;
            r_idata <= '0;
            r_ierr  <= 1'b0;
        end else begin
            if (!i_req) begin
                r_ierr <= 1'b0;
            end
            if (w_done && (r_state == ST_BUSY_I)) begin
                r_iv    <= 1'b1;
                r_iaddr <= r_maddr;
                r_idata <= m_rdata;
                r_ierr  <= 1'b0;
            end
            // A store over the cached fetch word makes that word stale.
            if (w_done && (r_state == ST_BUSY_D) && r_mwe
                && (r_maddr == r_iaddr)) begin
                r_iv <= 1'b0;
            end
            if (w_abort && (r_state == ST_BUSY_I)) begin
                r_ierr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dv     <= 1'b0;
            r_daddr  <= '0;
            r_dwe    <= 1'b0;
            r_dwdata <= '0;
            r_ddata  <= '0;
            r_derr   <= 1'b0;
        end else begin
            if (!d_req) begin
                r_derr <= 1'b0;
            end
            if (w_done && (r_state == ST_BUSY_D)) begin
                r_dv     <= 1'b1;
                r_daddr  <= r_maddr;
                r_dwe    <= r_mwe;
                r_dwdata <= r_mwdata;
                r_ddata  <= r_mwe ? r_mwdata : m_rdata;
                r_derr   <= 1'b0;
            end
            if (w_abort && (r_state == ST_BUSY_D)) begin
                r_derr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, buffering,
// coherence, timeout and reset behaviour of mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic [1:0]  i_status;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic [1:0]  d_status;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    bit ack_en   = 1'b1;
    int lat      = 2;
    int late_req = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_status (i_status),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_status (d_status),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .err      (err)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] v;
        case (a)
            32'h0040_0000: v = 32'h2402_0005;
            32'h0040_0004: v = 32'h8FA4_0000;
            32'h0040_0008: v = 32'h3C01_1001;
            32'h0040_000C: v = 32'h0000_0013;
            32'h0040_0010: v = 32'h0000_0093;
            32'h1001_0000: v = 32'h1111_2222;
            default:       v = 32'hBAD0_0000;
        endcase
        return v;
    endfunction

    // Memory model: acks after lat cycles of m_req, or once on demand.
    initial begin
        int cnt;
        int seen;
        cnt     = 0;
        seen    = 0;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack = 1'b0;
            if (late_req != seen) begin
                seen    = late_req;
                m_ack   = 1'b1;
                m_rdata = 32'h55AA_55AA;
            end else if (ack_en && m_req) begin
                cnt++;
                if (cnt >= lat) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_rd(m_addr);
                    cnt     = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_grant(input string tag, output logic [31:0] a,
                              output logic w);
        int n;
        n = 0;
        while (m_req && n < 200) begin
            tick();
            n++;
        end
        while (!m_req && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 200), 32'd1);
        a = m_addr;
        w = m_we;
    endtask

    task automatic wait_st(input string tag, input bit is_d,
                           input logic [1:0] want);
        int n;
        n = 0;
        while (((is_d ? d_status : i_status) !== want) && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_req && n < 200) begin
            tick();
            n++;
        end
        check("idle_to", 32'(n < 200), 32'd1);
        tick();
    endtask

    initial begin
        logic [31:0] ga;
        logic        gw;
        int          td;
        int          ti;

        rst     = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) tick();
        check("rst_mreq",  32'(m_req), 32'd0);
        check("rst_ist",   32'(i_status), 32'd0);
        check("rst_dst",   32'(d_status), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_irdat", i_rdata, 32'd0);
        rst = 1'b1;
        tick();

        // Fetch only, ack two cycles after m_req.
        lat    = 2;
        i_req  = 1'b1;
        i_addr = 32'h0040_0000;
        settle();
        check("f_c0_st",   32'(i_status), 32'd1);
        check("f_c0_mreq", 32'(m_req), 32'd0);
        tick();
        check("f_c1_mreq", 32'(m_req), 32'd1);
        check("f_c1_addr", m_addr, 32'h0040_0000);
        check("f_c1_we",   32'(m_we), 32'd0);
        tick();
        check("f_c2_st",   32'(i_status), 32'd1);
        tick();
        check("f_c3_st",   32'(i_status), 32'd2);
        check("f_c3_data", i_rdata, 32'h2402_0005);
        check("f_c3_mreq", 32'(m_req), 32'd0);
        tick();
        check("f_hold_st",   32'(i_status), 32'd2);
        check("f_hold_mreq", 32'(m_req), 32'd0);
        i_addr = 32'h0040_0004;
        settle();
        check("f_new_st", 32'(i_status), 32'd1);
        wait_grant("f_new_gnt", ga, gw);
        check("f_new_addr", ga, 32'h0040_0004);
        wait_st("f_new_done", 1'b0, 2'b10);
        check("f_new_data", i_rdata, 32'h8FA4_0000);
        i_req = 1'b0;
        settle();
        check("f_drop_st", 32'(i_status), 32'd0);
        wait_idle();

        // Simultaneous miss: data first, fetch next.
        lat    = 1;
        i_req  = 1'b1;
        i_addr = 32'h0040_0008;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1001_0000;
        tick();
        check("sim_gnt_addr", m_addr, 32'h1001_0000);
        check("sim_gnt_we",   32'(m_we), 32'd0);
        td = -1;
        ti = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (td < 0 && d_status == 2'b10) td = c;
            if (ti < 0 && i_status == 2'b10) ti = c;
        end
        check("sim_d_cycle", 32'(td), 32'd0);
        check("sim_i_cycle", 32'(ti), 32'd2);
        check("sim_d_data",  d_rdata, 32'h1111_2222);
        check("sim_i_data",  i_rdata, 32'h3C01_1001);
        i_req = 1'b0;
        d_req = 1'b0;
        wait_idle();

        // Starvation: data keeps a fresh miss, fetch wins after 4 losses.
        i_req  = 1'b1;
        i_addr = 32'h0040_000C;
        d_req  = 1'b1;
        d_addr = 32'h1001_0010;
        for (int k = 0; k < 4; k++) begin
            wait_grant("stv_gnt", ga, gw);
            check("stv_data_addr", ga, 32'h1001_0010 + 32'(4 * k));
            d_addr = 32'h1001_0014 + 32'(4 * k);
        end
        wait_grant("stv_gnt5", ga, gw);
        check("stv_fetch_win", ga, 32'h0040_000C);
        wait_grant("stv_gnt6", ga, gw);
        check("stv_data_only", ga, 32'h1001_0020);
        i_addr = 32'h0040_0010;
        d_addr = 32'h1001_0024;
        wait_grant("stv_gnt7", ga, gw);
        check("stv_cnt_clr", ga, 32'h1001_0024);
        wait_grant("stv_gnt8", ga, gw);
        check("stv_fetch_last", ga, 32'h0040_0010);
        i_req = 1'b0;
        d_req = 1'b0;
        wait_idle();

        // Store over the cached fetch word.
        i_req  = 1'b1;
        i_addr = 32'h1001_0000;
        wait_st("coh_fetch", 1'b0, 2'b10);
        check("coh_fdata", i_rdata, 32'h1111_2222);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1001_0000;
        d_wdata = 32'hDEAD_BEEF;
        wait_grant("coh_gnt", ga, gw);
        check("coh_maddr",  ga, 32'h1001_0000);
        check("coh_mwe",    32'(gw), 32'd1);
        check("coh_mwdata", m_wdata, 32'hDEAD_BEEF);
        wait_st("coh_sdone", 1'b1, 2'b10);
        check("coh_inval", 32'(i_status), 32'd1);
        check("coh_drdata", d_rdata, 32'hDEAD_BEEF);
        wait_grant("coh_refetch", ga, gw);
        check("coh_ref_addr", ga, 32'h1001_0000);
        check("coh_ref_we",   32'(gw), 32'd0);
        wait_st("coh_ref_done", 1'b0, 2'b10);
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        wait_idle();

        // Timeout: no ack for the whole window.
        ack_en = 1'b0;
        d_req  = 1'b1;
        d_addr = 32'h1001_0040;
        wait_grant("tmo_gnt", ga, gw);
        repeat (63) tick();
        check("tmo_63_mreq", 32'(m_req), 32'd1);
        check("tmo_63_err",  32'(err), 32'd0);
        check("tmo_63_st",   32'(d_status), 32'd1);
        tick();
        check("tmo_64_mreq", 32'(m_req), 32'd0);
        check("tmo_64_err",  32'(err), 32'd1);
        check("tmo_64_st",   32'(d_status), 32'd3);
        tick();
        check("tmo_hold_st",   32'(d_status), 32'd3);
        check("tmo_hold_mreq", 32'(m_req), 32'd0);
        d_req = 1'b0;
        settle();
        check("tmo_drop_st",  32'(d_status), 32'd0);
        check("tmo_drop_err", 32'(err), 32'd1);
        tick();

        // Reset in the middle of a data access.
        d_req  = 1'b1;
        d_addr = 32'h1001_0050;
        wait_grant("rst_gnt", ga, gw);
        check("rst_gnt_addr", ga, 32'h1001_0050);
        tick();
        rst = 1'b0;
        settle();
        check("rmid_mreq",  32'(m_req), 32'd0);
        check("rmid_dst",   32'(d_status), 32'd0);
        check("rmid_ist",   32'(i_status), 32'd0);
        check("rmid_err",   32'(err), 32'd0);
        d_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        late_req++;
        repeat (3) tick();
        check("late_mreq", 32'(m_req), 32'd0);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1001_0050;
        i_req  = 1'b1;
        i_addr = 32'h1001_0000;
        settle();
        check("late_dst",   32'(d_status), 32'd1);
        check("late_ist",   32'(i_status), 32'd1);
        check("late_drdat", d_rdata, 32'd0);
        check("late_irdat", i_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
